// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          SRAM_DW       = 16;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one SRAM half-access; last_o marks its final cycle.
module sram_wait_counter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic last_o
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(ACCESS_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses and freezes the pipeline until the pair completes.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
  parameter int          SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        val_Rm,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               WB_en_in,
  input  logic [3:0]         dst_in,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [31:0]        mem_result,
  output logic               ready,
  output logic               freeze,
  output logic [31:0]        ALU_res_out,
  output logic [3:0]         dst_out,
  output logic               WB_en_out,
  output logic               mem_read_out
);

  localparam int WW = SRAM_AW - 1;

  state_t        state_q, state_d;
  logic [WW-1:0] word_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   mem_result_q;
  logic          req, cnt_load, cnt_last, in_phase, is_high;
  logic [31:0]   byte_off;
  logic          unused_off_bits;

  assign req      = mem_read_in | mem_write_in;
  assign byte_off = ALU_res - BASE_ADDR;
  // Addresses outside the SRAM window simply wrap modulo its size.
  assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

  sram_wait_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d  = LOW;
        cnt_load = 1'b1;
      end
      LOW: if (cnt_last) begin
        state_d  = HIGH;
        cnt_load = 1'b1;
      end
      HIGH: if (cnt_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      mem_result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        word_q  <= byte_off[SRAM_AW:2];
        wdata_q <= val_Rm;
        wr_q    <= mem_write_in;  // read+write together resolves to a write
      end
      // Read data is sampled on the final cycle of each half-access.
      if (!wr_q && cnt_last) begin
        if (state_q == LOW)  mem_result_q[15:0]  <= sram_rdata;
        if (state_q == HIGH) mem_result_q[31:16] <= sram_rdata;
      end
    end
  end

  assign in_phase = (state_q == LOW) || (state_q == HIGH);
  assign is_high  = (state_q == HIGH);

  assign sram_addr  = in_phase ? {word_q, is_high} : '0;
  assign sram_wdata = (in_phase && wr_q) ? (is_high ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign sram_we_n  = !(in_phase && wr_q);
  assign sram_oe_n  = !(in_phase && !wr_q);

  assign mem_result = mem_result_q;
  assign ready      = (state_q == DONE);
  assign freeze     = ((state_q == IDLE) && req) || in_phase;

  assign ALU_res_out  = ALU_res;
  assign dst_out      = dst_in;
  assign WB_en_out    = WB_en_in;
  assign mem_read_out = mem_read_in;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM model.
module tb_mem_stage_sram_ctrl;

  localparam int AC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_res, val_Rm;
  logic        mem_read_in, mem_write_in, WB_en_in;
  logic [3:0]  dst_in;
  logic [15:0] sram_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we_n, sram_oe_n;
  logic [31:0] mem_result;
  logic        ready, freeze;
  logic [31:0] ALU_res_out;
  logic [3:0]  dst_out;
  logic        WB_en_out, mem_read_out;

  int npass = 0;
  int ntotal = 0;

  logic [15:0] sram [0:262143];

  always #5 clk = ~clk;

  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_wdata;
  assign sram_rdata = sram_oe_n ? 16'h0 : sram[sram_addr];

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(AC), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .ALU_res(ALU_res), .val_Rm(val_Rm),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .WB_en_in(WB_en_in),
    .dst_in(dst_in), .sram_rdata(sram_rdata), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .mem_result(mem_result), .ready(ready), .freeze(freeze),
    .ALU_res_out(ALU_res_out), .dst_out(dst_out), .WB_en_out(WB_en_out),
    .mem_read_out(mem_read_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    mem_read_in = 0; mem_write_in = 0; WB_en_in = 0; dst_in = 0;
    ALU_res = 0; val_Rm = 0;
  endtask

  // Called just after a rising edge; walks cycles 0..2*AC+1 of one access.
  task automatic mem_op(input logic wr, input logic rd, input logic [31:0] alu,
                        input logic [31:0] rm, input logic [17:0] lo_addr,
                        input logic [31:0] exp_res);
    logic hi;
    mem_write_in = wr; mem_read_in = rd; ALU_res = alu; val_Rm = rm;
    WB_en_in = rd; dst_in = 4'd1;
    @(negedge clk);
    chk("c0_freeze", freeze, 1);
    chk("c0_we_n", sram_we_n, 1);
    chk("c0_oe_n", sram_oe_n, 1);
    for (int c = 1; c <= 2*AC; c++) begin
      @(negedge clk);
      hi = (c > AC);
      chk($sformatf("c%0d_addr", c), sram_addr, lo_addr | {17'd0, hi});
      chk($sformatf("c%0d_we_n", c), sram_we_n, !wr);
      chk($sformatf("c%0d_oe_n", c), sram_oe_n, wr);
      chk($sformatf("c%0d_freeze", c), freeze, 1);
      chk($sformatf("c%0d_ready", c), ready, 0);
      if (wr) chk($sformatf("c%0d_wdata", c), sram_wdata, hi ? rm[31:16] : rm[15:0]);
    end
    @(negedge clk);
    chk("done_ready", ready, 1);
    chk("done_freeze", freeze, 0);
    chk("done_we_n", sram_we_n, 1);
    chk("done_oe_n", sram_oe_n, 1);
    chk("done_result", mem_result, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_freeze", freeze, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_result", mem_result, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Store then load at 1032 -> word 2, half-addresses 4/5
    mem_op(1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    mem_op(0, 1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
    idle_inputs();

    // Non-memory op: no stall, combinational pass-through
    ALU_res = 32'h55; WB_en_in = 1; dst_in = 4'd3;
    @(negedge clk);
    chk("nm_freeze", freeze, 0);
    chk("nm_alu", ALU_res_out, 32'h55);
    chk("nm_dst", dst_out, 3);
    chk("nm_wb", WB_en_out, 1);
    chk("nm_mrd", mem_read_out, 0);
    chk("nm_we_n", sram_we_n, 1);
    chk("nm_oe_n", sram_oe_n, 1);
    @(posedge clk); #1;
    ALU_res = 32'hA5A5_0000; dst_in = 4'd9; WB_en_in = 0;
    #1;
    chk("nm2_alu", ALU_res_out, 32'hA5A5_0000);
    chk("nm2_dst", dst_out, 9);
    chk("nm2_wb", WB_en_out, 0);
    @(negedge clk);
    chk("nm2_freeze", freeze, 0);
    @(posedge clk); #1;
    idle_inputs();

    // Back-to-back store/load at 1024, no gap between them
    mem_op(1, 0, 32'd1024, 32'hCAFEF00D, 18'd0, 32'hDEADBEEF);
    mem_op(0, 1, 32'd1024, 32'h0, 18'd0, 32'hCAFEF00D);

    // Read and write together acts as a write; mem_result untouched
    mem_op(1, 1, 32'd1028, 32'h0BADC0DE, 18'd2, 32'hCAFEF00D);
    mem_op(0, 1, 32'd1028, 32'h0, 18'd2, 32'h0BADC0DE);
    idle_inputs();

    // Reset during the second cycle of a store's low phase
    mem_write_in = 1; ALU_res = 32'd1040; val_Rm = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    @(negedge clk);
    chk("abort_freeze", freeze, 0);
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_addr", sram_addr, 0);
    chk("abort_ready", ready, 0);
    chk("abort_result", mem_result, 0);
    @(posedge clk); #1;
    mem_op(0, 1, 32'd1024, 32'h0, 18'd0, 32'hCAFEF00D);
    idle_inputs();

    // Below BASE_ADDR: word wraps to all ones
    mem_op(1, 0, 32'd1020, 32'h11223344, 18'h3FFFE, 32'hCAFEF00D);
    mem_op(0, 1, 32'd1020, 32'h0, 18'h3FFFE, 32'h11223344);
    idle_inputs();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
